// File: rtl/ram_2rw_be.sv
// ram_2rw_be: two read/write ports with byte enables, selectable read-during-write
// ordering, optional output register, a bulk-clear sweep and a collision flag.
module ram_2rw_be #(
  parameter int DW       = 16,
  parameter int AW       = 10,
  parameter int WR_FIRST = 0,
  parameter int OUT_REG  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_a,
  input  logic [AW-1:0]   addr_a,
  input  logic            write_a,
  input  logic [DW/8-1:0] be_a,
  input  logic [DW-1:0]   wdata_a,
  output logic [DW-1:0]   rdata_a,
  output logic            rvalid_a,
  input  logic            en_b,
  input  logic [AW-1:0]   addr_b,
  input  logic            write_b,
  input  logic [DW/8-1:0] be_b,
  input  logic [DW-1:0]   wdata_b,
  output logic [DW-1:0]   rdata_b,
  output logic            rvalid_b,
  input  logic            clr,
  output logic            busy,
  output logic            coll
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Array starts zeroed at configuration; reset never touches it.
  logic [DW-1:0] r_mem [DEPTH] = '{default: '0};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_coll;

  // Per-port views so both ports share one description (index 0 = A, 1 = B).
  logic          w_en    [2];
  logic [AW-1:0] w_addr  [2];
  logic          w_write [2];
  logic [NB-1:0] w_be    [2];
  logic [DW-1:0] w_wdata [2];
  logic          w_acc   [2];
  logic [DW-1:0] w_rd    [2];
  logic          r_s1_v  [2];
  logic [DW-1:0] r_s1_d  [2];
  logic          w_out_v [2];
  logic [DW-1:0] w_out_d [2];

  assign w_en[0]    = en_a;
  assign w_en[1]    = en_b;
  assign w_addr[0]  = addr_a;
  assign w_addr[1]  = addr_b;
  assign w_write[0] = write_a;
  assign w_write[1] = write_b;
  assign w_be[0]    = be_a;
  assign w_be[1]    = be_b;
  assign w_wdata[0] = wdata_a;
  assign w_wdata[1] = wdata_b;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign busy = (r_state == S_CLEAR);

  // Qualify accesses with busy and form each port's read word; only write-first merges own write data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_acc[p] = w_en[p] & ~busy;
      if ((WR_FIRST != 0) && w_write[p]) begin
        w_rd[p] = merge_bytes(r_mem[w_addr[p]], w_wdata[p], w_be[p]);
      end else begin
        w_rd[p] = r_mem[w_addr[p]];
      end
    end
  end

  // First read stage: capture the word for every qualified access, hold data otherwise.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        r_s1_v[p] <= 1'b0;
        r_s1_d[p] <= '0;
      end else begin
        r_s1_v[p] <= w_acc[p];
        if (w_acc[p]) begin
          r_s1_d[p] <= w_rd[p];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          r_s2_v [2];
      logic [DW-1:0] r_s2_d [2];

      // Second read stage: forward stage-1 results one cycle later, holding data between reads.
      always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
          if (rst) begin
            r_s2_v[p] <= 1'b0;
            r_s2_d[p] <= '0;
          end else begin
            r_s2_v[p] <= r_s1_v[p];
            if (r_s1_v[p]) begin
              r_s2_d[p] <= r_s1_d[p];
            end
          end
        end
      end

      // Outputs come from the second stage.
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          w_out_v[p] = r_s2_v[p];
          w_out_d[p] = r_s2_d[p];
        end
      end
    end else begin : g_no_out_reg
      // Outputs come straight from the first stage.
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          w_out_v[p] = r_s1_v[p];
          w_out_d[p] = r_s1_d[p];
        end
      end
    end
  endgenerate

  assign rdata_a  = w_out_d[0];
  assign rvalid_a = w_out_v[0];
  assign rdata_b  = w_out_d[1];
  assign rvalid_b = w_out_v[1];

  // Flag a same-address conflict where at least one side writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_acc[0] & w_acc[1] & (addr_a == addr_b) & (write_a | write_b);
    end
  end

  assign coll = r_coll;

  // Clear FSM state and sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear FSM next state: IDLE waits for clr, CLEAR walks the counter to the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (r_cnt == {AW{1'b1}}) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array update: clear sweep, or byte-masked port writes with port A applied last so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else begin
        for (int p = 1; p >= 0; p--) begin
          if (w_acc[p] && w_write[p]) begin
            for (int i = 0; i < NB; i++) begin
              if (w_be[p][i]) begin
                r_mem[w_addr[p]][8*i +: 8] <= w_wdata[p][8*i +: 8];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_2rw_be.sv
// tb_ram_2rw_be: drives two instances (read-first/latency 1 and write-first/latency 2)
// with identical stimulus and compares them against a behavioural model.
module tb_ram_2rw_be;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 clr;
  logic [1:0]           en;
  logic [1:0]           wr;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][1:0]      be;
  logic [1:0][DW-1:0]   wd;

  logic [1:0][DW-1:0]   o_rdata_a;
  logic [1:0][DW-1:0]   o_rdata_b;
  logic [1:0]           o_rvalid_a;
  logic [1:0]           o_rvalid_b;
  logic [1:0]           o_busy;
  logic [1:0]           o_coll;

  int n_checks;
  int n_errors;

  // Instance 0: read-first, latency 1. Instance 1: write-first, latency 2.
  ram_2rw_be #(.DW(DW), .AW(AW), .WR_FIRST(0), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en[0]), .addr_a(addr[0]), .write_a(wr[0]), .be_a(be[0]), .wdata_a(wd[0]),
    .rdata_a(o_rdata_a[0]), .rvalid_a(o_rvalid_a[0]),
    .en_b(en[1]), .addr_b(addr[1]), .write_b(wr[1]), .be_b(be[1]), .wdata_b(wd[1]),
    .rdata_b(o_rdata_b[0]), .rvalid_b(o_rvalid_b[0]),
    .clr(clr), .busy(o_busy[0]), .coll(o_coll[0])
  );

  ram_2rw_be #(.DW(DW), .AW(AW), .WR_FIRST(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_a(en[0]), .addr_a(addr[0]), .write_a(wr[0]), .be_a(be[0]), .wdata_a(wd[0]),
    .rdata_a(o_rdata_a[1]), .rvalid_a(o_rvalid_a[1]),
    .en_b(en[1]), .addr_b(addr[1]), .write_b(wr[1]), .be_b(be[1]), .wdata_b(wd[1]),
    .rdata_b(o_rdata_b[1]), .rvalid_b(o_rvalid_b[1]),
    .clr(clr), .busy(o_busy[1]), .coll(o_coll[1])
  );

  // ---------------- behavioural reference ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_cnt;
  bit            m_coll;
  bit            m_rv [2][2];   // [instance][port] expected rvalid
  logic [DW-1:0] m_rd [2][2];   // expected rdata (held between reads)
  bit            m_pv [2][2];   // read pending one more cycle (latency-2 instance)
  logic [DW-1:0] m_pd [2][2];

  function automatic logic [DW-1:0] merge16(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [1:0] b);
    logic [DW-1:0] r;
    r = o;
    if (b[0]) r[7:0]  = n[7:0];
    if (b[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  function automatic logic get_rv(input int d, input int p);
    return (p == 0) ? o_rvalid_a[d] : o_rvalid_b[d];
  endfunction

  function automatic logic [DW-1:0] get_rd(input int d, input int p);
    return (p == 0) ? o_rdata_a[d] : o_rdata_b[d];
  endfunction

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [DW-1:0] word;
    bit            take;
    bit            open;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          m_rv[d][p] = 1'b0; m_rd[d][p] = '0; m_pv[d][p] = 1'b0; m_pd[d][p] = '0;
        end
      end
      m_coll = 1'b0; m_busy = 1'b0; m_cnt = 0;
    end else begin
      open = !m_busy;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          take = en[p] && open;
          word = m_mem[addr[p]];
          if (d == 1 && wr[p]) word = merge16(word, wd[p], be[p]);
          if (d == 0) begin
            m_rv[d][p] = take;
            if (take) m_rd[d][p] = word;
          end else begin
            m_rv[d][p] = m_pv[d][p];
            if (m_pv[d][p]) m_rd[d][p] = m_pd[d][p];
            m_pv[d][p] = take;
            if (take) m_pd[d][p] = word;
          end
        end
      end
      m_coll = open && en[0] && en[1] && (addr[0] == addr[1]) && (wr[0] || wr[1]);
      if (m_busy) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin
          m_busy = 1'b0; m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (en[1] && wr[1]) m_mem[addr[1]] = merge16(m_mem[addr[1]], wd[1], be[1]);
        if (en[0] && wr[0]) m_mem[addr[0]] = merge16(m_mem[addr[0]], wd[0], be[0]);
        if (clr) begin
          m_busy = 1'b1; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clr = 1'b0; en = '0; wr = '0; addr = '0; be = '0; wd = '0;
  endtask

  task automatic write_a(input int a, input logic [DW-1:0] v, input logic [1:0] b);
    idle_inputs();
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = a[AW-1:0]; be[0] = b; wd[0] = v;
    step();
    idle_inputs();
  endtask

  task automatic fill_all(input logic [DW-1:0] v);
    for (int w = 0; w < DEPTH; w++) write_a(w, v, 2'b11);
  endtask

  // Read one word on port A and let both latencies drain; rdata then holds the value.
  task automatic read_word_a(input int a);
    idle_inputs();
    en[0] = 1'b1; addr[0] = a[AW-1:0];
    step();
    idle_inputs();
    step();
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; clr = 1'b1;
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 4'd2; be[0] = 2'b11; wd[0] = 16'hDEAD;
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_busy[d] !== 1'b0) begin n_errors++; $display("FAIL reset_busy dut%0d got %b want 0", d, o_busy[d]); end
      n_checks++; if (o_coll[d] !== 1'b0) begin n_errors++; $display("FAIL reset_coll dut%0d got %b want 0", d, o_coll[d]); end
      n_checks++; if ({o_rvalid_a[d], o_rvalid_b[d]} !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid dut%0d got %b%b want 00", d, o_rvalid_a[d], o_rvalid_b[d]); end
      n_checks++; if (o_rdata_a[d] !== 16'h0000 || o_rdata_b[d] !== 16'h0000) begin n_errors++; $display("FAIL reset_rdata dut%0d got %h/%h want 0000/0000", d, o_rdata_a[d], o_rdata_b[d]); end
    end
    idle_inputs();
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_busy[d] !== 1'b0) begin n_errors++; $display("FAIL reset_clr_priority dut%0d busy got %b want 0", d, o_busy[d]); end
    end
    // A read in flight is flushed by reset.
    en[0] = 1'b1; addr[0] = 4'd2;
    step();
    idle_inputs(); rst = 1'b1;
    step();
    idle_inputs();
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_rvalid_a[d] !== 1'b0) begin n_errors++; $display("FAIL reset_flush dut%0d rvalid_a got %b want 0", d, o_rvalid_a[d]); end
    end
    // Write under reset must not land; array starts at zero.
    read_word_a(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_rdata_a[d] !== 16'h0000) begin n_errors++; $display("FAIL reset_no_write dut%0d got %h want 0000", d, o_rdata_a[d]); end
    end
  endtask

  task automatic test_write_read();
    write_a(5, 16'hBEEF, 2'b11);
    en[1] = 1'b1; addr[1] = 4'd5;
    for (int s = 0; s < 3; s++) begin
      step();
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (o_rvalid_b[d] !== m_rv[d][1]) begin n_errors++; $display("FAIL wr_rd_rvalid dut%0d cyc%0d got %b want %b", d, s, o_rvalid_b[d], m_rv[d][1]); end
        n_checks++; if (o_rdata_b[d] !== m_rd[d][1]) begin n_errors++; $display("FAIL wr_rd_rdata dut%0d cyc%0d got %h want %h", d, s, o_rdata_b[d], m_rd[d][1]); end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_rdata_b[d] !== 16'hBEEF) begin n_errors++; $display("FAIL wr_rd_value dut%0d got %h want BEEF", d, o_rdata_b[d]); end
    end
  endtask

  task automatic test_rdw();
    logic [DW-1:0] want;
    write_a(7, 16'h1234, 2'b11);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 4'd7; be[0] = 2'b10; wd[0] = 16'hAB00;
    for (int s = 0; s < 3; s++) begin
      step();
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (o_rvalid_a[d] !== m_rv[d][0] || o_rdata_a[d] !== m_rd[d][0]) begin
          n_errors++; $display("FAIL rdw_port_a dut%0d cyc%0d got %b/%h want %b/%h", d, s, o_rvalid_a[d], o_rdata_a[d], m_rv[d][0], m_rd[d][0]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      want = (d == 0) ? 16'h1234 : 16'hAB34;
      n_checks++; if (o_rdata_a[d] !== want) begin n_errors++; $display("FAIL rdw_value dut%0d got %h want %h", d, o_rdata_a[d], want); end
    end
    en[1] = 1'b1; addr[1] = 4'd7;
    step(); idle_inputs(); step(); step();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_rdata_b[d] !== 16'hAB34) begin n_errors++; $display("FAIL rdw_after dut%0d got %h want AB34", d, o_rdata_b[d]); end
    end
  endtask

  task automatic test_cross_port();
    write_a(8, 16'h0F0F, 2'b11);
    en = 2'b11; wr[0] = 1'b1; addr[0] = 4'd8; addr[1] = 4'd8; be[0] = 2'b11; wd[0] = 16'hA5A5;
    step(); idle_inputs(); step(); step();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_rdata_b[d] !== 16'h0F0F) begin n_errors++; $display("FAIL cross_pre_write dut%0d got %h want 0F0F", d, o_rdata_b[d]); end
    end
  endtask

  task automatic test_collision();
    int pulses [2];
    pulses[0] = 0; pulses[1] = 0;
    idle_inputs();
    en = 2'b11; wr = 2'b11; addr[0] = 4'd3; addr[1] = 4'd3;
    be[0] = 2'b11; wd[0] = 16'h1111; be[1] = 2'b01; wd[1] = 16'h2222;
    for (int s = 0; s < 5; s++) begin
      step();
      idle_inputs();
      if (s == 1) begin
        en = 2'b11; addr[0] = 4'd3; addr[1] = 4'd3;   // same-address reads: no conflict
      end
      for (int d = 0; d < 2; d++) begin
        if (o_coll[d] === 1'b1) pulses[d]++;
        n_checks++; if (o_coll[d] !== m_coll) begin n_errors++; $display("FAIL coll_cycle dut%0d cyc%0d got %b want %b", d, s, o_coll[d], m_coll); end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (pulses[d] != 1) begin n_errors++; $display("FAIL coll_pulses dut%0d got %0d want 1", d, pulses[d]); end
      n_checks++; if (o_rdata_a[d] !== 16'h1111 || o_rdata_b[d] !== 16'h1111) begin
        n_errors++; $display("FAIL coll_merge dut%0d got %h/%h want 1111/1111", d, o_rdata_a[d], o_rdata_b[d]);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt [2];
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    fill_all(16'hFFFF);
    idle_inputs();
    clr = 1'b1; en[0] = 1'b1; addr[0] = 4'd1;   // read in flight as busy rises
    for (int s = 0; s < 21; s++) begin
      step();
      idle_inputs();
      if (s == 0) begin
        en = 2'b11; wr[0] = 1'b1; addr[0] = 4'd2; be[0] = 2'b11; wd[0] = 16'h5555; addr[1] = 4'd3;
      end
      if (s == 4) clr = 1'b1;   // ignored while busy
      for (int d = 0; d < 2; d++) begin
        if (o_busy[d] === 1'b1) busy_cnt[d]++;
        n_checks++; if (o_busy[d] !== m_busy) begin n_errors++; $display("FAIL clear_busy dut%0d cyc%0d got %b want %b", d, s, o_busy[d], m_busy); end
        n_checks++; if (o_rvalid_a[d] !== m_rv[d][0] || o_rvalid_b[d] !== m_rv[d][1]) begin
          n_errors++; $display("FAIL clear_rvalid dut%0d cyc%0d got %b%b want %b%b", d, s, o_rvalid_a[d], o_rvalid_b[d], m_rv[d][0], m_rv[d][1]);
        end
        n_checks++; if (o_coll[d] !== 1'b0) begin n_errors++; $display("FAIL clear_coll dut%0d cyc%0d got %b want 0", d, s, o_coll[d]); end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (busy_cnt[d] != DEPTH) begin n_errors++; $display("FAIL clear_busy_len dut%0d got %0d want %0d", d, busy_cnt[d], DEPTH); end
    end
    for (int w = 0; w < DEPTH; w++) begin
      read_word_a(w);
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (o_rdata_a[d] !== 16'h0000) begin n_errors++; $display("FAIL clear_word dut%0d addr%0d got %h want 0000", d, w, o_rdata_a[d]); end
      end
    end
  endtask

  task automatic test_rst_during_clear();
    logic [DW-1:0] want;
    fill_all(16'hFFFF);
    idle_inputs(); clr = 1'b1;
    step();
    idle_inputs();
    for (int s = 0; s < 5; s++) step();
    rst = 1'b1;   // sixth CLEAR cycle
    step();
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (o_busy[d] !== 1'b0) begin n_errors++; $display("FAIL abort_busy dut%0d got %b want 0", d, o_busy[d]); end
    end
    for (int w = 0; w < DEPTH; w++) begin
      read_word_a(w);
      want = (w < 5) ? 16'h0000 : 16'hFFFF;
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (o_rdata_a[d] !== want) begin n_errors++; $display("FAIL abort_word dut%0d addr%0d got %h want %h", d, w, o_rdata_a[d], want); end
      end
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < DEPTH; w++) write_a(w, 16'($urandom), 2'b11);
    for (int s = 0; s < 300; s++) begin
      idle_inputs();
      if (s < 150) begin
        en = 2'b11;
        addr[0] = AW'($urandom_range(0, DEPTH - 1));
        addr[1] = AW'($urandom_range(0, DEPTH - 1));
      end else begin
        en = 2'($urandom); wr = 2'($urandom);
        addr[0] = AW'($urandom_range(0, 7)); addr[1] = AW'($urandom_range(0, 7));
        be[0] = 2'($urandom); be[1] = 2'($urandom);
        wd[0] = 16'($urandom); wd[1] = 16'($urandom);
      end
      step();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          n_checks++; if (get_rv(d, p) !== m_rv[d][p]) begin n_errors++; $display("FAIL rand_rvalid dut%0d port%0d cyc%0d got %b want %b", d, p, s, get_rv(d, p), m_rv[d][p]); end
          n_checks++; if (get_rd(d, p) !== m_rd[d][p]) begin n_errors++; $display("FAIL rand_rdata dut%0d port%0d cyc%0d got %h want %h", d, p, s, get_rd(d, p), m_rd[d][p]); end
        end
        n_checks++; if (o_coll[d] !== m_coll) begin n_errors++; $display("FAIL rand_coll dut%0d cyc%0d got %b want %b", d, s, o_coll[d], m_coll); end
        n_checks++; if (o_busy[d] !== m_busy) begin n_errors++; $display("FAIL rand_busy dut%0d cyc%0d got %b want %b", d, s, o_busy[d], m_busy); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int w = 0; w < DEPTH; w++) m_mem[w] = '0;
    m_busy = 1'b0; m_cnt = 0; m_coll = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        m_rv[d][p] = 1'b0; m_rd[d][p] = '0; m_pv[d][p] = 1'b0; m_pd[d][p] = '0;
      end
    end
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_rdw();
    test_cross_port();
    test_collision();
    test_clear();
    test_rst_during_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_2rw_be.md
RAM_2RW_BE -- requirements
Module: ram_2rw_be

Interface
REQ-001 SHALL have parameter DW, default 16, data width in bits; DW SHALL be a multiple of 8.
REQ-002 SHALL have parameter AW, default 10, address width; DEPTH = 2**AW words.
REQ-003 SHALL have parameter WR_FIRST, default 0: 0 = read-first, 1 = write-first for same-port read-during-write.
REQ-004 SHALL have parameter OUT_REG, default 0: 0 = read latency 1, 1 = read latency 2 (extra output register).
REQ-005 SHALL have the port clk  in  1  single clock; all logic is on its rising edge.
REQ-006 SHALL have the port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have, for each port p in {a,b}: en_p  in  1  access enable.
REQ-008 SHALL have addr_p  in  AW  word address.
REQ-009 SHALL have write_p  in  1  write when en_p=1.
REQ-010 SHALL have be_p  in  DW/8  byte write enables; bit i covers bits [8i+7:8i].
REQ-011 SHALL have wdata_p  in  DW  write data.
REQ-012 SHALL have rdata_p  out  DW  read data.
REQ-013 SHALL have rvalid_p  out  1  one-cycle pulse marking rdata_p valid.
REQ-014 SHALL have clr  in  1  request to zero the whole array.
REQ-015 SHALL have busy  out  1  high while a clear is in progress.
REQ-016 SHALL have coll  out  1  registered pulse flagging a same-address access conflict.

Function
REQ-017 Write: when en_p=1, write_p=1 and busy=0, bytes with be_p[i]=1 SHALL update at addr_p on the edge; bytes with be_p[i]=0 SHALL keep their value.
REQ-018 Read: every access with en_p=1 and busy=0, write or not, SHALL return the word at addr_p.
REQ-019 The read SHALL appear on rdata_p with rvalid_p=1 exactly 1 cycle after the access (OUT_REG=0) or exactly 2 cycles after it (OUT_REG=1).
REQ-020 rdata_p SHALL hold its last value while rvalid_p=0.
REQ-021 Same-port read-during-write, WR_FIRST=0: rdata_p SHALL return the pre-write word.
REQ-022 Same-port read-during-write, WR_FIRST=1: rdata_p SHALL return the merged post-write word.
REQ-023 Cross-port, same address, one port writing: the reading port SHALL return the pre-write word in both modes.
REQ-024 Both ports write the same address in the same cycle: for bytes enabled on both ports, port A data SHALL win; bytes enabled on only one port SHALL take that port's data.
REQ-025 coll SHALL pulse high for 1 cycle, 1 cycle after any cycle where en_a=en_b=1, addr_a=addr_b, busy=0 and at least one port writes.
REQ-026 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-027 IDLE -> CLEAR when clr=1; the address counter SHALL load 0 and busy SHALL go high the next cycle.
REQ-028 In CLEAR, one word per cycle SHALL be written with 0, counter ascending 0..DEPTH-1.
REQ-029 CLEAR -> IDLE after word DEPTH-1 is written; busy SHALL be high for exactly DEPTH cycles.
REQ-030 clr while busy=1 SHALL be ignored.
REQ-031 While busy=1, port accesses SHALL be dropped: no writes, no rvalid, no coll.
REQ-032 Reads already in the output pipeline when busy rises SHALL still complete.
REQ-033 Array contents SHALL be zero at FPGA configuration.

Reset
REQ-034 rst=1 SHALL force rdata_a=rdata_b=0, rvalid_a=rvalid_b=0, coll=0, busy=0, FSM=IDLE, counter=0, and flush the OUT_REG pipeline stage, on the next edge.
REQ-035 rst SHALL NOT alter array contents.
REQ-036 rst during CLEAR SHALL abort the clear; words already zeroed stay zero and the rest keep their old values.
REQ-037 rst SHALL take priority over clr and over port accesses in the same cycle.

Verification
REQ-038 Write A addr 5 = 0xBEEF (be=11), then read B addr 5 -> rvalid_b with rdata_b=0xBEEF after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-039 addr 7 holds 0x1234; A writes 0xAB00 with be=10 and reads addr 7 in the same cycle -> rdata_a=0x1234 (WR_FIRST=0) or 0xAB34 (WR_FIRST=1); addr 7 then reads 0xAB34.
REQ-040 addr 3 holds 0x0000; A writes 0x1111 with be=11 and B writes 0x2222 with be=01 to addr 3 in the same cycle -> addr 3 = 0x1111, coll pulses once.
REQ-041 With AW=4, fill every word with 0xFFFF, pulse clr -> busy high 16 cycles, all words read 0x0000, and a port A write during busy is lost.
REQ-042 With AW=4, assert rst on the 6th CLEAR cycle -> busy=0 next cycle, words 0..4 read 0x0000, words 5..15 read 0xFFFF.
REQ-043 Simultaneous reads on both ports every cycle over a random address sequence -> both ports match a reference model with no rvalid gaps.
